sha256_msg_sched: RTL and testbench

Sequencing controller for the SHA-256 message-schedule datapath. It loads one 512-bit block as sixteen 32-bit words over a valid/ready input, then streams W[0]..W[63] in order over a valid/ready output to the compression-round logic. It holds the 16-word sliding window and produces each new word W[t+16] with a single shared expansion datapath.

---
 rtl/sha256_pkg.sv | 13 +
 rtl/sha256_w_expand.sv | 25 ++
 rtl/sha256_msg_sched.sv | 85 ++++++++
 tb/tb_sha256_msg_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and the sequencing state type for the SHA-256 message schedule.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int WIN_DEPTH = 16;
  localparam int ROUNDS    = 64;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational SHA-256 schedule expansion: W[t] from W[t-16], W[t-15], W[t-7], W[t-2].
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w_m16,
  input  logic [WORD_W-1:0] w_m15,
  input  logic [WORD_W-1:0] w_m7,
  input  logic [WORD_W-1:0] w_m2,
  output logic [WORD_W-1:0] w_new
);

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Four-operand modular add; carries out of bit 31 are dropped by the width.
  always_comb begin
    w_new = w_m16 + sig0(w_m15) + w_m7 + sig1(w_m2);
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: loads 16 words, then streams W[0]..W[63]
// from a 16-word sliding window refilled by one shared expansion datapath.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_out,
  output logic [5:0]        w_idx,
  output logic              w_last,
  output logic              busy
);

  sched_state_e      r_state;
  logic [3:0]        r_ld_cnt;
  logic [5:0]        r_idx;
  logic [WORD_W-1:0] r_win [WIN_DEPTH];

  logic              w_in_hs;
  logic              w_out_hs;
  logic [WORD_W-1:0] w_exp;

  assign w_in_hs  = (r_state == LOAD) && in_valid;
  assign w_out_hs = (r_state == EMIT) && w_ready;

  sha256_w_expand u_expand (
    .w_m16 (r_win[0]),
    .w_m15 (r_win[1]),
    .w_m7  (r_win[9]),
    .w_m2  (r_win[14]),
    .w_new (w_exp)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= LOAD;
      r_ld_cnt <= '0;
      r_idx    <= '0;
      for (int k = 0; k < WIN_DEPTH; k++) r_win[k] <= '0;
    end else begin
      // Window shifts on either handshake; only the refill source differs.
      if (w_in_hs || w_out_hs) begin
        for (int k = 0; k < WIN_DEPTH - 1; k++) r_win[k] <= r_win[k+1];
        r_win[WIN_DEPTH-1] <= w_in_hs ? in_word : w_exp;
      end
      case (r_state)
        LOAD: begin
          if (w_in_hs) begin
            if (r_ld_cnt == 4'(WIN_DEPTH - 1)) begin
              r_ld_cnt <= '0;
              r_idx    <= '0;
              r_state  <= EMIT;
            end else begin
              r_ld_cnt <= r_ld_cnt + 4'd1;
            end
          end
        end
        EMIT: begin
          if (w_out_hs) begin
            if (r_idx == 6'(ROUNDS - 1)) begin
              r_idx   <= '0;
              r_state <= LOAD;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign in_ready = (r_state == LOAD);
  assign w_valid  = (r_state == EMIT);
  assign busy     = (r_state == EMIT);
  assign w_out    = r_win[0];
  assign w_idx    = r_idx;
  assign w_last   = (r_state == EMIT) && (r_idx == 6'(ROUNDS - 1));

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a full-array SHA-256 schedule model.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_out;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;

  sha256_msg_sched dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_out    (w_out),
    .w_idx    (w_idx),
    .w_last   (w_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          blocks_done = 0;
  int          last_hs_cyc = 0;
  int          w0_cyc = 0;
  bit          stall_mode = 1'b0;
  logic [31:0] blk  [16];
  logic [31:0] wexp [64];
  logic [31:0] cap  [64];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule over the whole 64-entry array.
  function automatic void compute_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wexp[t] = blk[t];
      else wexp[t] = (rotr(wexp[t-2], 17) ^ rotr(wexp[t-2], 19) ^ (wexp[t-2] >> 10))
                     + wexp[t-7]
                     + (rotr(wexp[t-15], 7) ^ rotr(wexp[t-15], 18) ^ (wexp[t-15] >> 3))
                     + wexp[t-16];
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      w_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    logic [5:0]  exp_idx = '0;
    int          nword = 0;
    bit          prev_valid = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_out = '0;
    logic [5:0]  prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_idx = '0; nword = 0; prev_valid = 1'b0; prev_stall = 1'b0;
      end else begin
        if (w_valid) begin
          chk("w_idx", {26'd0, w_idx}, {26'd0, exp_idx});
          chk("w_out", w_out, wexp[exp_idx]);
          chk("w_last", {31'd0, w_last}, {31'd0, exp_idx == 6'd63});
          chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
          chk("busy_emit", {31'd0, busy}, 32'd1);
          if (prev_stall) begin
            chk("stall_w_out", w_out, prev_out);
            chk("stall_w_idx", {26'd0, w_idx}, {26'd0, prev_idx});
          end
          if (!prev_valid) w0_cyc = cyc;
          if (w_ready) begin
            cap[w_idx] = w_out;
            nword++;
            if (exp_idx == 6'd63) begin
              chk("words_per_block", nword, 64);
              blocks_done++;
              last_hs_cyc = cyc;
              nword = 0;
            end
            exp_idx = exp_idx + 6'd1;
          end
          prev_stall = !w_ready;
          prev_out   = w_out;
          prev_idx   = w_idx;
        end else begin
          chk("in_ready_load", {31'd0, in_ready}, 32'd1);
          chk("busy_load", {31'd0, busy}, 32'd0);
          chk("w_last_load", {31'd0, w_last}, 32'd0);
          prev_stall = 1'b0;
        end
        prev_valid = w_valid;
      end
    end
  end

  task automatic load_words(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        repeat (i % 3) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_block_done();
    int prev = blocks_done;
    bit done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clk);
      #2;
      if (blocks_done != prev) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL block_timeout: got no w_last handshake, expected one within 2000 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_w_valid"}, {31'd0, w_valid}, 32'd0);
    chk({tag, "_w_out"}, w_out, 32'd0);
    chk({tag, "_w_idx"}, {26'd0, w_idx}, 32'd0);
    chk({tag, "_w_last"}, {31'd0, w_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  initial begin
    int t_first;
    bit hit;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    for (int i = 0; i < 64; i++) begin wexp[i] = '0; cap[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_outputs("por");

    // "abc" block, no stalls.
    set_abc();
    compute_model();
    chk("model_W16", wexp[16], 32'h61626380);
    chk("model_W17", wexp[17], 32'h000F0000);
    chk("model_W63", wexp[63], 32'h12B1EDEB);
    load_words(16, 1'b0);
    chk("w_valid_after_load", {31'd0, w_valid}, 32'd1);
    wait_block_done();
    chk("in_ready_after_last", {31'd0, in_ready}, 32'd1);
    chk("cap_W0", cap[0], 32'h61626380);
    chk("cap_W15", cap[15], 32'h00000018);
    chk("cap_W16", cap[16], 32'h61626380);
    chk("cap_W17", cap[17], 32'h000F0000);
    chk("cap_W63", cap[63], 32'h12B1EDEB);

    // Same block with random consumer stalls.
    stall_mode = 1'b1;
    load_words(16, 1'b0);
    wait_block_done();
    stall_mode = 1'b0;
    chk("stall_cap_W63", cap[63], 32'h12B1EDEB);

    // Gapped load, then in_valid held with junk during EMIT.
    set_random();
    compute_model();
    load_words(16, 1'b1);
    in_valid = 1'b1;
    in_word  = $urandom;
    wait_block_done();
    in_valid = 1'b0;

    // Two blocks back-to-back at full rate.
    set_random();
    compute_model();
    load_words(16, 1'b0);
    wait_block_done();
    t_first = last_hs_cyc;
    set_random();
    compute_model();
    load_words(16, 1'b0);
    wait_block_done();
    chk("b2b_w0_latency", w0_cyc - t_first, 17);

    // Reset in the middle of emission at w_idx == 30.
    set_random();
    compute_model();
    load_words(16, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk);
      #2;
      if (w_valid && w_idx == 6'd30) hit = 1'b1;
    end
    chk("reached_idx30", {31'd0, hit}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_outputs("rst_emit");
    set_random();
    compute_model();
    load_words(16, 1'b0);
    wait_block_done();

    // Reset after 7 loaded words; the next 16 words form the block.
    set_random();
    load_words(7, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_outputs("rst_load");
    set_abc();
    compute_model();
    load_words(16, 1'b0);
    wait_block_done();
    chk("rst_load_cap_W0", cap[0], 32'h61626380);
    chk("rst_load_cap_W63", cap[63], 32'h12B1EDEB);
    chk("blocks_total", blocks_done, 7);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
